mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Pipeline MEM-stage data-memory access unit, sitting between the EX/MEM and MEM/WB pipeline registers. It converts load/store requests into word-aligned, byte-enabled transactions on a req/ack data-memory bus. It stalls the pipeline until the bus acknowledges and extracts and sign/zero-extends load data. Its read-data output feeds the MEM/WB register's read-data input. It also flags misaligned accesses and bus timeouts.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles REQ may stay high without ACK before the access is aborted (1..255).
- CLK  in  1  rising-edge clock.
- RESET_N  in  1  reset; one clock, reset asynchronous and active-low.
- I_MEM_READ  in  1  load request.
- I_MEM_WRITE  in  1  store request.
- I_MEM_SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- I_MEM_UNSIGNED  in  1  zero-extend loads when 1, sign-extend when 0.
- I_MEM_ADDR  in  32  byte address.
- I_MEM_WDATA  in  32  store data, right-justified.
- O_DM_REQ  out  1  bus request, registered.
- O_DM_WE  out  1  1 = write.
- O_DM_ADDR  out  32  {I_MEM_ADDR[31:2],2'b00}, registered.
- O_DM_BE  out  4  byte enables, bit n = byte lane n.
- O_DM_WDATA  out  32  lane-replicated store data.
- I_DM_RDATA  in  32  read data, valid with ACK.
- I_DM_ACK  in  1  transaction complete.
- O_MEM_ReadData  out  32  extracted load result.
- O_MEM_STALL  out  1  freeze upstream stages and hold MEM/WB input.
- O_MEM_ALIGN_ERR  out  1  one-cycle pulse on a misaligned access.
- O_MEM_BUS_ERR  out  1  one-cycle pulse on a timeout.

## Operation
- FSM states: IDLE, ACCESS, DONE. Reset enters IDLE.
- Op valid = I_MEM_READ | I_MEM_WRITE. If both are high, the op is a write.
- Misaligned: half with ADDR[0]=1, or word with ADDR[1:0]≠0.
- IDLE, valid and aligned:
  - Register REQ=1, WE, ADDR, BE, WDATA.
  - Clear the timeout counter.
  - Go to ACCESS.
- IDLE, valid and misaligned:
  - No bus request, no stall.
  - O_MEM_ALIGN_ERR=1 for that cycle; stay in IDLE.
- ACCESS:
  - On I_DM_ACK: drop REQ; for a read, latch the extracted data; go to DONE.
  - Otherwise increment the counter.
  - When the counter reaches TIMEOUT_CYCLES: drop REQ, set ReadData=0, pulse O_MEM_BUS_ERR, go to DONE.
- DONE: one cycle, then IDLE.
- Little-endian lane selection by ADDR[1:0]:
  - byte → lane ADDR[1:0]; half → lanes {ADDR[1],0}.
  - BE: byte 0001<<ADDR[1:0]; half 0011<<{ADDR[1],0}; word 1111.
- Store data: byte {4{WDATA[7:0]}}, half {2{WDATA[15:0]}}, word WDATA.
- Load extraction: select the lane, then extend to 32 bits per I_MEM_UNSIGNED; a word load is passed through.
- O_MEM_ReadData holds its value until the next load completes or times out.
- Stores never modify O_MEM_ReadData.

## Timing
- Reset values (asynchronous, immediate on RESET_N=0):
  - O_DM_REQ, O_DM_WE=0.
  - O_DM_ADDR, O_DM_WDATA, O_MEM_ReadData=0.
  - O_DM_BE=0000.
  - O_MEM_STALL, O_MEM_ALIGN_ERR, O_MEM_BUS_ERR=0.
  - FSM in IDLE, counter 0.
- Reset mid-ACCESS: REQ drops immediately. The aborted transaction is not retried, and a late ACK is ignored in IDLE.
- O_MEM_STALL is combinational:
  - 1 in IDLE with a valid aligned op.
  - 1 in ACCESS.
  - 0 in DONE, which is the advance cycle.
- Upstream holds all I_MEM_* stable while O_MEM_STALL=1.
- Latency, op presented in cycle 0:
  - REQ high from cycle 1.
  - ACK sampled in cycle k ≥ 1; DONE in cycle k+1 with ReadData valid and the stall released.
  - Minimum 3 cycles per access.
- ACK in IDLE or DONE is ignored.
- ACK in the same cycle the counter hits TIMEOUT_CYCLES: ACK wins, no BUS_ERR.
- Back-to-back ops: DONE→IDLE, then the new op is accepted the following cycle.

## Test plan
- Aligned LW, ADDR=0x100, ACK in the first REQ cycle, RDATA=0xDEADBEEF → O_DM_ADDR=0x100, BE=1111, STALL high for 2 cycles, ReadData=0xDEADBEEF in DONE.
- LB signed, ADDR=0x103, RDATA=0x80112233 → BE=1000, ReadData=0xFFFFFF80. LBU, same address and data → ReadData=0x00000080.
- SH, ADDR=0x202, WDATA=0x0000ABCD → O_DM_ADDR=0x200, BE=1100, O_DM_WDATA=0xABCDABCD, WE=1, ReadData unchanged.
- LW, ADDR=0x101 → ALIGN_ERR pulse, no REQ, STALL=0.
- LH, ADDR=0x10, ACK never arrives, TIMEOUT_CYCLES=4 → REQ high exactly 4 cycles, BUS_ERR pulse, ReadData=0, STALL then drops.
- RESET_N low in the 2nd ACCESS cycle, with ACK arriving after release → all outputs 0 immediately, FSM in IDLE, late ACK ignored, next LW completes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// mem_access_stage
// ----------------
// MEM-stage data-memory access unit. It takes a load/store request from the
// EX/MEM register and turns it into one word-aligned, byte-enabled req/ack bus
// transaction. It holds the pipeline stalled until the bus acknowledges, then
// extracts and extends the load data for the MEM/WB register.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   I_MEM_READ/WRITE        load / store request (both high => store)
//   I_MEM_SIZE              00 byte, 01 half, 10/11 word
//   I_MEM_UNSIGNED          zero-extend (1) or sign-extend (0) loads
//   I_MEM_ADDR, I_MEM_WDATA byte address, right-justified store data
//   O_DM_*                  registered bus request: REQ, WE, ADDR, BE, WDATA
//   I_DM_RDATA, I_DM_ACK    bus read data and completion
//   O_MEM_ReadData          extracted load result (held between loads)
//   O_MEM_STALL             combinational pipeline freeze
//   O_MEM_ALIGN_ERR         pulse in the cycle a misaligned op is presented
//   O_MEM_BUS_ERR           pulse in the DONE cycle of a timed-out access
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        I_MEM_READ,
  input  logic        I_MEM_WRITE,
  input  logic [1:0]  I_MEM_SIZE,
  input  logic        I_MEM_UNSIGNED,
  input  logic [31:0] I_MEM_ADDR,
  input  logic [31:0] I_MEM_WDATA,
  output logic        O_DM_REQ,
  output logic        O_DM_WE,
  output logic [31:0] O_DM_ADDR,
  output logic [3:0]  O_DM_BE,
  output logic [31:0] O_DM_WDATA,
  input  logic [31:0] I_DM_RDATA,
  input  logic        I_DM_ACK,
  output logic [31:0] O_MEM_ReadData,
  output logic        O_MEM_STALL,
  output logic        O_MEM_ALIGN_ERR,
  output logic        O_MEM_BUS_ERR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  // Counter value of the last ACCESS cycle before the access is abandoned.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_reg;
  logic [7:0]  cnt_reg;
  logic        req_reg;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        bus_err_reg;
  // Access attributes kept for load extraction when ACK arrives.
  logic [1:0]  lane_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;

  logic        op_valid;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [7:0]  rd_lane [4];
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign op_valid = I_MEM_READ | I_MEM_WRITE;

  always_comb begin
    case (I_MEM_SIZE)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = I_MEM_ADDR[0];
      default: misaligned = (I_MEM_ADDR[1:0] != 2'b00);
    endcase
  end

  always_comb begin
    case (I_MEM_SIZE)
      2'b00: begin
        be_next    = 4'b0001 << I_MEM_ADDR[1:0];
        wdata_next = {4{I_MEM_WDATA[7:0]}};
      end
      2'b01: begin
        be_next    = I_MEM_ADDR[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{I_MEM_WDATA[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = I_MEM_WDATA;
      end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_lane[gi] = I_DM_RDATA[8*gi +: 8];
  end

  always_comb begin
    ld_byte = rd_lane[lane_reg];
    ld_half = lane_reg[1] ? I_DM_RDATA[31:16] : I_DM_RDATA[15:0];
    case (size_reg)
      2'b00:   ld_data = {{24{~uns_reg & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{~uns_reg & ld_half[15]}}, ld_half};
      default: ld_data = I_DM_RDATA;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= IDLE;
      cnt_reg     <= 8'd0;
      req_reg     <= 1'b0;
      we_reg      <= 1'b0;
      addr_reg    <= 32'd0;
      be_reg      <= 4'b0000;
      wdata_reg   <= 32'd0;
      rdata_reg   <= 32'd0;
      bus_err_reg <= 1'b0;
      lane_reg    <= 2'b00;
      size_reg    <= 2'b00;
      uns_reg     <= 1'b0;
    end else begin
      bus_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (op_valid && !misaligned) begin
            req_reg   <= 1'b1;
            we_reg    <= I_MEM_WRITE;
            addr_reg  <= {I_MEM_ADDR[31:2], 2'b00};
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
            lane_reg  <= I_MEM_ADDR[1:0];
            size_reg  <= I_MEM_SIZE;
            uns_reg   <= I_MEM_UNSIGNED;
            cnt_reg   <= 8'd0;
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          // ACK is checked first so it wins over a simultaneous timeout.
          if (I_DM_ACK) begin
            req_reg <= 1'b0;
            if (!we_reg) begin
              rdata_reg <= ld_data;
            end
            state_reg <= DONE;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            req_reg <= 1'b0;
            if (!we_reg) begin
              rdata_reg <= 32'd0;
            end
            bus_err_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign O_DM_REQ       = req_reg;
  assign O_DM_WE        = we_reg;
  assign O_DM_ADDR      = addr_reg;
  assign O_DM_BE        = be_reg;
  assign O_DM_WDATA     = wdata_reg;
  assign O_MEM_ReadData = rdata_reg;
  assign O_MEM_BUS_ERR  = bus_err_reg;

  // Combinational flags are forced low while reset is asserted so that every
  // output reads zero during reset regardless of the request inputs.
  assign O_MEM_STALL = RESET_N &&
                       (((state_reg == IDLE) && op_valid && !misaligned) ||
                        (state_reg == ACCESS));
  assign O_MEM_ALIGN_ERR = RESET_N && (state_reg == IDLE) && op_valid && misaligned;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        I_MEM_READ, I_MEM_WRITE, I_MEM_UNSIGNED;
  logic [1:0]  I_MEM_SIZE;
  logic [31:0] I_MEM_ADDR, I_MEM_WDATA;
  logic        O_DM_REQ, O_DM_WE;
  logic [31:0] O_DM_ADDR, O_DM_WDATA;
  logic [3:0]  O_DM_BE;
  logic [31:0] I_DM_RDATA;
  logic        I_DM_ACK;
  logic [31:0] O_MEM_ReadData;
  logic        O_MEM_STALL, O_MEM_ALIGN_ERR, O_MEM_BUS_ERR;

  mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .I_MEM_READ(I_MEM_READ), .I_MEM_WRITE(I_MEM_WRITE), .I_MEM_SIZE(I_MEM_SIZE),
    .I_MEM_UNSIGNED(I_MEM_UNSIGNED), .I_MEM_ADDR(I_MEM_ADDR), .I_MEM_WDATA(I_MEM_WDATA),
    .O_DM_REQ(O_DM_REQ), .O_DM_WE(O_DM_WE), .O_DM_ADDR(O_DM_ADDR), .O_DM_BE(O_DM_BE),
    .O_DM_WDATA(O_DM_WDATA), .I_DM_RDATA(I_DM_RDATA), .I_DM_ACK(I_DM_ACK),
    .O_MEM_ReadData(O_MEM_ReadData), .O_MEM_STALL(O_MEM_STALL),
    .O_MEM_ALIGN_ERR(O_MEM_ALIGN_ERR), .O_MEM_BUS_ERR(O_MEM_BUS_ERR)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        exp_req, exp_stall, exp_align, exp_bus, exp_we;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] model_rd;
  logic        chk_en = 1'b0;

  // Observations gathered by the compare process.
  int          stall_cnt = 0, req_cnt = 0, align_cnt = 0, bus_cnt = 0;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_be;
  logic        seen_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return a[0];
    return a[1:0] != 2'd0;
  endfunction

  function automatic logic [3:0] be_f(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    if (sz == 2'd1) return 4'(3 << (2 * a[1]));
    return 4'hF;
  endfunction

  function automatic logic [31:0] wd_f(input logic [1:0] sz, input logic [31:0] w);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ext_f(input logic [31:0] r, input logic [1:0] sz,
                                        input logic [31:0] a, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (r >> (8 * a[1:0])) & 32'hFF;
      if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      v = (r >> (16 * a[1])) & 32'hFFFF;
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  always @(negedge CLK) begin
    if (chk_en) begin
      check("req", {31'd0, O_DM_REQ}, {31'd0, exp_req});
      check("stall", {31'd0, O_MEM_STALL}, {31'd0, exp_stall});
      check("align_err", {31'd0, O_MEM_ALIGN_ERR}, {31'd0, exp_align});
      check("bus_err", {31'd0, O_MEM_BUS_ERR}, {31'd0, exp_bus});
      check("read_data", O_MEM_ReadData, model_rd);
      if (exp_req) begin
        check("dm_we", {31'd0, O_DM_WE}, {31'd0, exp_we});
        check("dm_addr", O_DM_ADDR, exp_addr);
        check("dm_be", {28'd0, O_DM_BE}, {28'd0, exp_be});
        check("dm_wdata", O_DM_WDATA, exp_wdata);
      end
      if (O_MEM_STALL) stall_cnt++;
      if (O_DM_REQ) begin
        req_cnt++;
        seen_addr  = O_DM_ADDR;
        seen_be    = O_DM_BE;
        seen_wdata = O_DM_WDATA;
        seen_we    = O_DM_WE;
      end
      if (O_MEM_ALIGN_ERR) align_cnt++;
      if (O_MEM_BUS_ERR) bus_cnt++;
    end
  end

  task automatic set_idle();
    I_MEM_READ = 0; I_MEM_WRITE = 0; I_MEM_SIZE = 0; I_MEM_UNSIGNED = 0;
    I_MEM_ADDR = 0; I_MEM_WDATA = 0; I_DM_ACK = 0;
    exp_req = 0; exp_stall = 0; exp_align = 0; exp_bus = 0;
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic idle_cycle();
    set_idle();
    I_DM_ACK = 1'($urandom_range(0, 1));
    I_DM_RDATA = $urandom;
    step();
    I_DM_ACK = 0;
  endtask

  // lat = ACCESS cycle (1-based) in which ACK is given; 0 means never.
  task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input logic [31:0] rdat, input int lat);
    logic bad;
    int   n;
    bad = misal(sz, ad);
    I_MEM_READ = rd; I_MEM_WRITE = wr; I_MEM_SIZE = sz; I_MEM_UNSIGNED = un;
    I_MEM_ADDR = ad; I_MEM_WDATA = wd; I_DM_ACK = 0; I_DM_RDATA = $urandom;
    exp_req = 0; exp_stall = !bad; exp_align = bad; exp_bus = 0;
    step();
    if (!bad) begin
      n = (lat == 0) ? TO : lat;
      for (int i = 1; i <= n; i++) begin
        exp_req = 1; exp_stall = 1; exp_align = 0; exp_we = wr;
        exp_addr = ad & 32'hFFFFFFFC; exp_be = be_f(sz, ad); exp_wdata = wd_f(sz, wd);
        I_DM_ACK = (i == lat);
        I_DM_RDATA = (i == lat) ? rdat : $urandom;
        step();
      end
      if (!wr) model_rd = (lat == 0) ? 32'd0 : ext_f(rdat, sz, ad, un);
      exp_req = 0; exp_stall = 0; exp_bus = (lat == 0);
      I_DM_ACK = 1'($urandom_range(0, 1));
      I_DM_RDATA = $urandom;
      step();
    end
    set_idle();
    $display("[TB] op rd=%0d wr=%0d sz=%0d uns=%0d addr=0x%08h lat=%0d rd_data=0x%08h",
             rd, wr, sz, un, ad, lat, O_MEM_ReadData);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, r0, a0, b0;
    RESET_N = 0;
    I_DM_RDATA = 0;
    model_rd = 0;
    exp_we = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0;
    set_idle();
    chk_en = 1;
    step(); step();
    RESET_N = 1;
    step();

    // Aligned LW, ACK in the first REQ cycle.
    s0 = stall_cnt;
    run_op(1, 0, 2'd2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    check("lw_stall_cycles", 32'(stall_cnt - s0), 32'd2);
    check("lw_addr", seen_addr, 32'h100);
    check("lw_be", {28'd0, seen_be}, 32'hF);
    check("lw_data", O_MEM_ReadData, 32'hDEADBEEF);

    // LB signed / unsigned from lane 3.
    run_op(1, 0, 2'd0, 0, 32'h103, 32'h0, 32'h80112233, 2);
    check("lb_be", {28'd0, seen_be}, 32'h8);
    check("lb_data", O_MEM_ReadData, 32'hFFFFFF80);
    run_op(1, 0, 2'd0, 1, 32'h103, 32'h0, 32'h80112233, 3);
    check("lbu_data", O_MEM_ReadData, 32'h00000080);

    // SH to upper half: store must not touch ReadData.
    run_op(0, 1, 2'd1, 0, 32'h202, 32'h0000ABCD, 32'h55555555, 1);
    check("sh_addr", seen_addr, 32'h200);
    check("sh_be", {28'd0, seen_be}, 32'hC);
    check("sh_wdata", seen_wdata, 32'hABCDABCD);
    check("sh_we", {31'd0, seen_we}, 32'd1);
    check("sh_rd_kept", O_MEM_ReadData, 32'h00000080);

    // Misaligned LW.
    r0 = req_cnt; a0 = align_cnt; s0 = stall_cnt;
    run_op(1, 0, 2'd2, 0, 32'h101, 32'h0, 32'h0, 1);
    check("mis_req", 32'(req_cnt - r0), 32'd0);
    check("mis_align", 32'(align_cnt - a0), 32'd1);
    check("mis_stall", 32'(stall_cnt - s0), 32'd0);

    // LH with no ACK: timeout.
    run_op(1, 0, 2'd0, 0, 32'h7, 32'h0, 32'h000000AA, 1);
    r0 = req_cnt; b0 = bus_cnt;
    run_op(1, 0, 2'd1, 0, 32'h10, 32'h0, 32'h0, 0);
    check("to_req_cycles", 32'(req_cnt - r0), 32'd4);
    check("to_bus_err", 32'(bus_cnt - b0), 32'd1);
    check("to_data", O_MEM_ReadData, 32'd0);

    // Reset in the 2nd ACCESS cycle, late ACK after release.
    run_op(1, 0, 2'd2, 0, 32'h80, 32'h0, 32'h12345678, 2);
    I_MEM_READ = 1; I_MEM_SIZE = 2'd2; I_MEM_ADDR = 32'h40;
    exp_stall = 1;
    step();
    exp_req = 1; exp_we = 0; exp_addr = 32'h40; exp_be = 4'hF; exp_wdata = 32'h0;
    step();
    RESET_N = 0;
    set_idle();
    model_rd = 0;
    #1;
    check("rst_req", {31'd0, O_DM_REQ}, 32'd0);
    check("rst_data", O_MEM_ReadData, 32'd0);
    check("rst_addr", O_DM_ADDR, 32'd0);
    check("rst_be", {28'd0, O_DM_BE}, 32'd0);
    @(posedge CLK); #1;
    RESET_N = 1;
    I_DM_ACK = 1; I_DM_RDATA = 32'hCAFEF00D;
    r0 = req_cnt;
    step();
    I_DM_ACK = 0;
    step();
    check("late_ack_ignored", 32'(req_cnt - r0), 32'd0);
    run_op(1, 0, 2'd2, 0, 32'h44, 32'h0, 32'h0BADF00D, 1);
    check("post_rst_lw", O_MEM_ReadData, 32'h0BADF00D);

    // Randomised traffic against the model.
    for (int t = 0; t < 150; t++) begin
      int kind;
      logic [1:0] sz;
      logic [31:0] ad;
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      ad = $urandom;
      if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
      run_op(kind != 1, kind != 0, sz, 1'($urandom_range(0, 1)), ad, $urandom, $urandom,
             $urandom_range(0, TO));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
